mult_div_issue_queue: RTL and testbench

MULT_DIV_ISSUE_QUEUE -- requirements
Module: mult_div_issue_queue

---
 rtl/mult_div_issue_queue.sv | 121 ++++++++++++
 tb/tb_mult_div_issue_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_issue_queue.sv
// In-order issue queue feeding the mult/div unit: circular FIFO of operand
// entries that snoop the CDB and issue strictly from the head.
package mult_div_issue_queue_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_data_valid;
    logic             rs2_data_valid;
  } queue_data;
endpackage

module mult_div_issue_queue
  import mult_div_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_en,
  input  queue_data                dispatch_data,
  output logic                     queue_full,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  input  logic                     flush,
  input  logic                     fu_ready,
  output logic                     issue_valid,
  output logic [XLEN-1:0]          issue_rs1_data,
  output logic [XLEN-1:0]          issue_rs2_data,
  output logic [TAG_W-1:0]         issue_rd_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  queue_data          entries [DEPTH];
  logic [DEPTH-1:0]   entry_valid;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               write;
  logic               pop;
  queue_data          head_entry;

  // Operand capture for an entry being written while the CDB broadcasts.
  function automatic queue_data capture(input queue_data d, input logic cv,
                                        input logic [TAG_W-1:0] ct,
                                        input logic [XLEN-1:0] cd);
    queue_data r;
    r = d;
    if (cv && !d.rs1_data_valid && d.rs1_tag == ct) begin
      r.rs1_data       = cd;
      r.rs1_data_valid = 1'b1;
    end
    if (cv && !d.rs2_data_valid && d.rs2_tag == ct) begin
      r.rs2_data       = cd;
      r.rs2_data_valid = 1'b1;
    end
    return r;
  endfunction

  assign head_entry     = entries[head];
  assign queue_full     = (count == CNT_W'(DEPTH));
  assign issue_valid    = (count != '0) && head_entry.rs1_data_valid && head_entry.rs2_data_valid;
  assign issue_rs1_data = head_entry.rs1_data;
  assign issue_rs2_data = head_entry.rs2_data;
  assign issue_rd_tag   = head_entry.rd_tag;

  assign write = dispatch_en && !queue_full;
  assign pop   = issue_valid && fu_ready;

  // Entry payload: CDB snoop on waiting operands, then the dispatch write.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && cdb_valid) begin
        if (!entries[i].rs1_data_valid && entries[i].rs1_tag == cdb_tag) begin
          entries[i].rs1_data       <= cdb_data;
          entries[i].rs1_data_valid <= 1'b1;
        end
        if (!entries[i].rs2_data_valid && entries[i].rs2_tag == cdb_tag) begin
          entries[i].rs2_data       <= cdb_data;
          entries[i].rs2_data_valid <= 1'b1;
        end
      end
    end
    if (write) begin
      entries[tail] <= capture(dispatch_data, cdb_valid, cdb_tag, cdb_data);
    end
  end

  // Occupancy and pointers; reset outranks flush, flush outranks everything else.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entry_valid <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (write) begin
        entry_valid[tail] <= 1'b1;
        tail              <= PTR_W'(tail + 1'b1);
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= PTR_W'(head + 1'b1);
      end
      case ({write, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Directed, table-driven bench for mult_div_issue_queue (DEPTH=4).
module tb_mult_div_issue_queue;
  import mult_div_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_en;
  queue_data   dispatch_data;
  logic        queue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        fu_ready;
  logic        issue_valid;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic [5:0]  issue_rd_tag;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  mult_div_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dispatch_en(dispatch_en), .dispatch_data(dispatch_data),
    .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_tag(issue_rd_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, den, cv, fr;
    queue_data   d;
    logic [5:0]  ct;
    logic [31:0] cd;
    int          ec;
    logic        ef, eiv, chk;
    logic [31:0] e1, e2;
    logic [5:0]  erd;
  } vec_t;

  vec_t vecs[$];

  function automatic queue_data qd(input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [5:0] t1, input logic [5:0] t2,
                                   input logic [5:0] rd, input logic v1, input logic v2);
    queue_data q;
    q.rs1_data = r1; q.rs2_data = r2; q.rs1_tag = t1; q.rs2_tag = t2;
    q.rd_tag = rd; q.rs1_data_valid = v1; q.rs2_data_valid = v2;
    return q;
  endfunction

  function automatic void add(input logic r, input logic fl, input logic den, input queue_data d,
                              input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                              input logic fr, input int ec, input logic ef, input logic eiv,
                              input logic chk, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [5:0] erd);
    vec_t v;
    v.rst = r; v.flush = fl; v.den = den; v.d = d; v.cv = cv; v.ct = ct; v.cd = cd;
    v.fr = fr; v.ec = ec; v.ef = ef; v.eiv = eiv; v.chk = chk; v.e1 = e1; v.e2 = e2;
    v.erd = erd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic den, input queue_data d,
                       input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                       input logic fr);
    rst = r; flush = fl; dispatch_en = den; dispatch_data = d;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; fu_ready = fr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    queue_data n, qa, qb, qc, qdd, qe, qf;
    bit seen;
    n   = '0;
    qa  = qd(32'h1, 32'h11, 6'h0, 6'h0, 6'h21, 1'b1, 1'b1);
    qb  = qd(32'h2, 32'h12, 6'h0, 6'h0, 6'h22, 1'b1, 1'b1);
    qc  = qd(32'h3, 32'h13, 6'h0, 6'h0, 6'h23, 1'b1, 1'b1);
    qdd = qd(32'h4, 32'h14, 6'h0, 6'h0, 6'h24, 1'b1, 1'b1);
    qe  = qd(32'h5, 32'h15, 6'h0, 6'h0, 6'h25, 1'b1, 1'b1);
    qf  = qd(32'h6, 32'h16, 6'h0, 6'h0, 6'h26, 1'b1, 1'b1);

    // rst fl den data                                    cv ct    cd          fr cnt full iv chk e1          e2          erd
    add(1, 0, 0, n,                                        0, 0,    0,          0, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qd(5, 7, 0, 0, 6'h12, 1, 1),              0, 0,    0,          1, 1, 0, 1, 1, 5,          7,          6'h12);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qd(1, 0, 0, 6'h21, 6'h13, 1, 0),          0, 0,    0,          1, 1, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 1, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        1, 6'h21, 32'hDEAD, 1, 1, 0, 1, 1, 1,          32'hDEAD,   6'h13);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qd(0, 9, 6'h21, 0, 6'h14, 0, 1),          1, 6'h21, 32'hBEEF, 0, 1, 0, 1, 1, 32'hBEEF,   9,          6'h14);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    // fill to full with wrap, fifth dispatch dropped, then drain with one write+pop
    add(0, 0, 1, qa,                                       0, 0,    0,          0, 1, 0, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 1, qb,                                       0, 0,    0,          0, 2, 0, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 1, qc,                                       0, 0,    0,          0, 3, 0, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 1, qdd,                                      0, 0,    0,          0, 4, 1, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 1, qe,                                       0, 0,    0,          0, 4, 1, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 3, 0, 1, 1, 2,          32'h12,     6'h22);
    add(0, 0, 1, qf,                                       0, 0,    0,          1, 3, 0, 1, 1, 3,          32'h13,     6'h23);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 2, 0, 1, 1, 4,          32'h14,     6'h24);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 1, 0, 1, 1, 6,          32'h16,     6'h26);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    // blocked head on tag 0x03 with a ready entry behind it
    add(0, 0, 1, qd(0, 2, 6'h03, 0, 6'h30, 0, 1),          0, 0,    0,          1, 1, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qd(3, 4, 0, 0, 6'h31, 1, 1),              0, 0,    0,          1, 2, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        1, 6'h05, 32'h555,  1, 2, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        1, 6'h03, 32'h333,  1, 2, 0, 1, 1, 32'h333,    2,          6'h30);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 1, 0, 1, 1, 3,          4,          6'h31);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    // flush with concurrent dispatch, then reset mid-drain
    add(0, 0, 1, qa,                                       0, 0,    0,          0, 1, 0, 1, 0, 0,          0,          0);
    add(0, 0, 1, qb,                                       0, 0,    0,          0, 2, 0, 1, 0, 0,          0,          0);
    add(0, 0, 1, qc,                                       0, 0,    0,          0, 3, 0, 1, 0, 0,          0,          0);
    add(0, 1, 1, qdd,                                      1, 6'h00, 32'h99,   1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qa,                                       0, 0,    0,          0, 1, 0, 1, 1, 1,          32'h11,     6'h21);
    add(0, 0, 1, qb,                                       0, 0,    0,          0, 2, 0, 1, 0, 0,          0,          0);
    add(0, 0, 1, qc,                                       0, 0,    0,          0, 3, 0, 1, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 2, 0, 1, 1, 2,          32'h12,     6'h22);
    add(1, 1, 1, qdd,                                      0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);
    add(0, 0, 1, qd(32'h77, 32'h88, 0, 0, 6'h3f, 1, 1),    0, 0,    0,          0, 1, 0, 1, 1, 32'h77,     32'h88,     6'h3f);
    add(0, 0, 0, n,                                        0, 0,    0,          1, 0, 0, 0, 0, 0,          0,          0);

    drive(1, 0, 0, n, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].den, vecs[i].d, vecs[i].cv, vecs[i].ct,
            vecs[i].cd, vecs[i].fr);
      step();
      check("count", i, 32'(count), 32'(vecs[i].ec));
      check("queue_full", i, 32'(queue_full), 32'(vecs[i].ef));
      check("issue_valid", i, 32'(issue_valid), 32'(vecs[i].eiv));
      if (vecs[i].chk) begin
        check("issue_rs1_data", i, issue_rs1_data, vecs[i].e1);
        check("issue_rs2_data", i, issue_rs2_data, vecs[i].e2);
        check("issue_rd_tag", i, 32'(issue_rd_tag), 32'(vecs[i].erd));
      end
    end

    // Both operands waiting on separate broadcasts arriving in different cycles.
    drive(0, 0, 1, qd(0, 0, 6'h2A, 6'h2B, 6'h3A, 0, 0), 0, 0, 0, 0);
    step();
    drive(0, 0, 0, n, 0, 0, 0, 0);
    step();
    check("seq_wait_both", 100, 32'(issue_valid), 32'd0);
    drive(0, 0, 0, n, 1, 6'h2B, 32'hB0B, 0);
    step();
    check("seq_one_of_two", 101, 32'(issue_valid), 32'd0);
    drive(0, 0, 0, n, 1, 6'h2A, 32'hA0A, 0);
    step();
    check("seq_issue_valid", 102, 32'(issue_valid), 32'd1);
    check("seq_rs1", 102, issue_rs1_data, 32'hA0A);
    check("seq_rs2", 102, issue_rs2_data, 32'hB0B);
    check("seq_rd", 102, 32'(issue_rd_tag), 32'h3A);
    drive(0, 0, 0, n, 0, 0, 0, 1);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (count == 3'd0) seen = 1'b1;
    end
    check("seq_drain_timeout", 103, 32'(seen), 32'd1);
    check("seq_empty_iv", 103, 32'(issue_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
